serial_slice_alu: RTL

- Multi-cycle, parametrised ALU that evaluates WIDTH-bit operands SLICE bits per clock, reusing one SLICE-wide adder/logic slice and carrying between cycles.
- Implements the MIPS-style control set AND/OR/ADD/SUB/SLT/NOR, including the overflow-corrected SLT at the MSB slice.
- Sits between the decode stage and the multi-cycle datapath's result register.
- Uses a valid/ready handshake on both input and output.

---
 rtl/serial_slice_alu.sv | 160 ++++++++++++++++
 1 files changed

// File: rtl/serial_slice_alu.sv
// serial_slice_alu
//   Multi-cycle MIPS-style ALU (AND/OR/ADD/SUB/SLT/NOR). Operands are
//   WIDTH bits wide and are consumed SLICE bits per clock, LSB first,
//   through one SLICE-wide add/logic slice. The carry is held in a
//   register between cycles. An operation takes WIDTH/SLICE cycles from
//   acceptance to out_valid.
//
// Ports
//   clk        rising-edge clock
//   rst        asynchronous active-high reset
//   in_valid   operands/control presented    in_ready  high only in IDLE
//   a, b       WIDTH-bit operands            alu_ctrl  {a_inv, b_inv, op[1:0]}
//   out_valid  result/zero/overflow valid    out_ready consumer accepts result
//   result     WIDTH-bit result              zero      result == 0
//   overflow   signed overflow (op == ADD form only)
module serial_slice_alu #(
  parameter int WIDTH = 32,
  parameter int SLICE = 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic [3:0]       alu_ctrl,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] result,
  output logic             zero,
  output logic             overflow
);

  localparam int N     = WIDTH / SLICE;
  localparam int CNT_W = (N > 1) ? $clog2(N) : 1;

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t             state_q, state_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic               carry_q, carry_d;
  logic [WIDTH-1:0]   a_q, a_d;
  logic [WIDTH-1:0]   b_q, b_d;
  logic [3:0]         ctrl_q, ctrl_d;
  logic [WIDTH-1:0]   sh_q, sh_d;
  logic [WIDTH-1:0]   result_q, result_d;
  logic               zero_q, zero_d;
  logic               ovf_q, ovf_d;

  // Datapath slice: invert, ripple add, op select
  logic [SLICE-1:0]       ai_s, bi_s, sum_s, slice_res;
  logic [SLICE:0]         c_s;
  logic [WIDTH+SLICE-1:0] sh_cat;
  logic [WIDTH-1:0]       sh_next, final_res;
  logic                   ovf_raw, set_bit;

  always_comb begin
    ai_s   = a_q[SLICE-1:0] ^ {SLICE{ctrl_q[3]}};
    bi_s   = b_q[SLICE-1:0] ^ {SLICE{ctrl_q[2]}};
    c_s    = '0;
    sum_s  = '0;
    c_s[0] = carry_q;
    for (int i = 0; i < SLICE; i++) begin
      sum_s[i]   = ai_s[i] ^ bi_s[i] ^ c_s[i];
      c_s[i+1]   = (ai_s[i] & bi_s[i]) | (c_s[i] & (ai_s[i] ^ bi_s[i]));
    end
    case (ctrl_q[1:0])
      2'b00:   slice_res = ai_s & bi_s;
      2'b01:   slice_res = ai_s | bi_s;
      2'b10:   slice_res = sum_s;
      default: slice_res = '0;
    endcase
    // Only meaningful on the MSB slice. set uses the true sign of the
    // sum, so SLT stays correct when the subtraction overflows.
    ovf_raw = c_s[SLICE-1] ^ c_s[SLICE];
    set_bit = sum_s[SLICE-1] ^ ovf_raw;
    // Concatenation form keeps the shift legal when WIDTH == SLICE.
    sh_cat    = {slice_res, sh_q};
    sh_next   = sh_cat[WIDTH+SLICE-1:SLICE];
    final_res = (ctrl_q[1:0] == 2'b11) ? WIDTH'(set_bit) : sh_next;
  end

  // Control and next-state
  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    carry_d  = carry_q;
    a_d      = a_q;
    b_d      = b_q;
    ctrl_d   = ctrl_q;
    sh_d     = sh_q;
    result_d = result_q;
    zero_d   = zero_q;
    ovf_d    = ovf_q;
    case (state_q)
      IDLE: begin
        if (in_valid) begin
          a_d     = a;
          b_d     = b;
          ctrl_d  = alu_ctrl;
          carry_d = alu_ctrl[2];
          cnt_d   = '0;
          sh_d    = '0;
          state_d = RUN;
        end
      end
      RUN: begin
        a_d     = a_q >> SLICE;
        b_d     = b_q >> SLICE;
        carry_d = c_s[SLICE];
        sh_d    = sh_next;
        cnt_d   = cnt_q + CNT_W'(1);
        if (cnt_q == CNT_W'(N - 1)) begin
          // Visible outputs change only here, so a partial result is never shown.
          result_d = final_res;
          zero_d   = (final_res == '0);
          ovf_d    = (ctrl_q[1:0] == 2'b10) ? ovf_raw : 1'b0;
          state_d  = DONE;
        end
      end
      DONE: begin
        if (out_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= IDLE;
      cnt_q    <= '0;
      carry_q  <= 1'b0;
      a_q      <= '0;
      b_q      <= '0;
      ctrl_q   <= '0;
      sh_q     <= '0;
      result_q <= '0;
      zero_q   <= 1'b0;
      ovf_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      carry_q  <= carry_d;
      a_q      <= a_d;
      b_q      <= b_d;
      ctrl_q   <= ctrl_d;
      sh_q     <= sh_d;
      result_q <= result_d;
      zero_q   <= zero_d;
      ovf_q    <= ovf_d;
    end
  end

  assign in_ready  = (state_q == IDLE);
  assign out_valid = (state_q == DONE);
  assign result    = result_q;
  assign zero      = zero_q;
  assign overflow  = ovf_q;

endmodule
